tile_deck_shuffler: RTL and testbench

Generates a randomized 10-tile deck (5 colour pairs) for the tile-matching game and presents it as a flat bus of 11-bit tile codes to the in-game controller. It sits directly upstream of the game FSM: the controller pulses `start` on the menu→in-game transition and reads tile codes from `deck` after `deck_valid` rises. Randomness comes from a free-running LFSR, so the time spent in the menu seeds the layout.

---
 rtl/tile_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 29 ++
 rtl/tile_deck_shuffler.sv | 129 ++++++++++++
 tb/tb_tile_deck_shuffler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants for the tile-matching game: tile code layout, deck size,
// LFSR seed/taps and the shuffle FSM state encoding.
package tile_pkg;

    // Tile code layout: [10:9] row, [8:7] col, [6:1] colour, [0] flipped
    localparam int unsigned CODE_W     = 11;
    localparam int unsigned ROW_LSB    = 9;
    localparam int unsigned ROW_W      = 2;
    localparam int unsigned COL_LSB    = 7;
    localparam int unsigned COL_W      = 2;
    localparam int unsigned COLOUR_LSB = 1;
    localparam int unsigned COLOUR_W   = 6;
    localparam int unsigned FLIP_BIT   = 0;

    localparam int unsigned NTILES   = 10;
    localparam int unsigned NCOLOURS = 5;

    // x^16 + x^14 + x^13 + x^11 + 1, stage n held in bit n-1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shuffle FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_PICK   = 3'd2;
    localparam logic [2:0] ST_REDUCE = 3'd3;
    localparam logic [2:0] ST_SWAP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Canonical layout: 4 tiles per row, colour pairs on adjacent positions
    function automatic logic [CODE_W-1:0] canonical_tile(input int unsigned k);
        logic [CODE_W-1:0] t;
        t = '0;
        t[ROW_LSB +: ROW_W]       = ROW_W'(k >> 2);
        t[COL_LSB +: COL_W]       = COL_W'(k);
        t[COLOUR_LSB +: COLOUR_W] = COLOUR_W'((k >> 1) + 1);
        t[FLIP_BIT]               = 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with synchronous reset to the seed.
// Nonzero seed plus a primitive polynomial keeps it away from the all-zero lock-up.
module lfsr16
    import tile_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] q
);

    logic [15:0] lfsr_q, lfsr_d;

    // Shift towards the MSB, feeding back the parity of the tapped stages
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // State register, advances every cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/tile_deck_shuffler.sv
// Builds a randomized deck of colour pairs using a Fisher-Yates shuffle over
// the colour fields only; row/col/flip stay tied to their deck position.
module tile_deck_shuffler #(
    parameter int unsigned NTILES = tile_pkg::NTILES,
    parameter int unsigned CODE_W = tile_pkg::CODE_W
) (
    input  logic                     CLOCK_50,
    input  logic                     userquit,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     deck_valid,
    output logic [NTILES*CODE_W-1:0] deck
);

    import tile_pkg::*;

    localparam logic [3:0] IDX_LAST = 4'(NTILES - 1);

    logic [15:0]       lfsr_q;
    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        r_q, r_d;
    logic              deck_valid_q, deck_valid_d;
    logic [CODE_W-1:0] deck_q [NTILES];
    logic [CODE_W-1:0] deck_d [NTILES];

    logic [3:0]          r_red;
    logic [COLOUR_W-1:0] colour_idx, colour_r;
    logic                unused_lfsr;

    lfsr16 u_lfsr (
        .clk_i (CLOCK_50),
        .rst_i (userquit),
        .q     (lfsr_q)
    );

    // Only the low nibble picks the swap partner
    assign unused_lfsr = ^lfsr_q[15:4];

    // Next-state logic for the shuffle FSM and deck contents
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        r_d          = r_q;
        deck_valid_d = deck_valid_q;
        deck_d       = deck_q;
        // Only evaluated as a result when r > i, so never underflows
        r_red        = r_q - (idx_q + 4'd1);
        colour_idx   = deck_q[idx_q][COLOUR_LSB +: COLOUR_W];
        colour_r     = deck_q[r_q][COLOUR_LSB +: COLOUR_W];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    deck_valid_d = 1'b0;
                end
            end
            ST_LOAD: begin
                for (int unsigned k = 0; k < NTILES; k++) begin
                    deck_d[k] = canonical_tile(k);
                end
                idx_d   = IDX_LAST;
                state_d = ST_PICK;
            end
            ST_PICK: begin
                r_d     = lfsr_q[3:0];
                // Skip REDUCE entirely when the draw is already in range
                state_d = (lfsr_q[3:0] > idx_q) ? ST_REDUCE : ST_SWAP;
            end
            ST_REDUCE: begin
                r_d     = r_red;
                state_d = (r_red > idx_q) ? ST_REDUCE : ST_SWAP;
            end
            ST_SWAP: begin
                // r == i writes the same colour back, a harmless no-op
                deck_d[idx_q][COLOUR_LSB +: COLOUR_W] = colour_r;
                deck_d[r_q][COLOUR_LSB +: COLOUR_W]   = colour_idx;
                idx_d = idx_q - 4'd1;
                if (idx_q == 4'd1) begin
                    state_d      = ST_DONE;
                    deck_valid_d = 1'b1;
                end else begin
                    state_d = ST_PICK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; userquit restores the canonical deck
    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            r_q          <= '0;
            deck_valid_q <= 1'b0;
            for (int unsigned k = 0; k < NTILES; k++) begin
                deck_q[k] <= canonical_tile(k);
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            r_q          <= r_d;
            deck_valid_q <= deck_valid_d;
            deck_q       <= deck_d;
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state_q == ST_LOAD) || (state_q == ST_PICK) ||
               (state_q == ST_REDUCE) || (state_q == ST_SWAP);
        done = (state_q == ST_DONE);
    end

    assign deck_valid = deck_valid_q;

    for (genvar g = 0; g < NTILES; g++) begin : g_deck
        assign deck[g*CODE_W +: CODE_W] = deck_q[g];
    end

endmodule

// File: tb/tb_tile_deck_shuffler.sv
// Randomized bench for tile_deck_shuffler against a behavioural shuffle model.
module tb_tile_deck_shuffler;

    localparam int NT = 10;
    localparam int CW = 11;

    logic             CLOCK_50 = 1'b0;
    logic             userquit = 1'b1;
    logic             start    = 1'b0;
    logic             busy, done, deck_valid;
    logic [NT*CW-1:0] deck;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr;

    always #5 CLOCK_50 = ~CLOCK_50;

    tile_deck_shuffler #(
        .NTILES (NT),
        .CODE_W (CW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .userquit   (userquit),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .deck_valid (deck_valid),
        .deck       (deck)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1, stages shift towards the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Reference LFSR: tracks what the generator holds in each cycle
    always @(posedge CLOCK_50) begin
        m_lfsr <= userquit ? 16'hACE1 : lfsr_next(m_lfsr);
    end

    function automatic logic [127:0] pack_deck(input int colour[NT]);
        logic [127:0] v;
        int code;
        v = '0;
        for (int k = 0; k < NT; k++) begin
            code = (k / 4) * 512 + (k % 4) * 128 + colour[k] * 2;
            v = v | (128'(code) << (k * CW));
        end
        return v;
    endfunction

    function automatic logic [127:0] canon_deck();
        int colour[NT];
        for (int k = 0; k < NT; k++) colour[k] = k / 2 + 1;
        return pack_deck(colour);
    endfunction

    function automatic int tile_of(input logic [127:0] d, input int k);
        return int'(d[k*CW +: CW]);
    endfunction

    // Cycle 0 is LOAD, holding LFSR value 'seed'; returns DONE cycle index
    task automatic model_shuffle(input logic [15:0] seed, output logic [127:0] exp_deck,
                                 output int done_off, output int reduce_off);
        int colour[NT];
        logic [15:0] x;
        int c, r, tmp;
        for (int k = 0; k < NT; k++) colour[k] = k / 2 + 1;
        x = lfsr_next(seed);
        c = 1;
        reduce_off = -1;
        for (int i = NT - 1; i >= 1; i--) begin
            r = int'(x[3:0]);
            c++;
            x = lfsr_next(x);
            while (r > i) begin
                if (reduce_off < 0) reduce_off = c;
                r = r - (i + 1);
                c++;
                x = lfsr_next(x);
            end
            tmp = colour[i];
            colour[i] = colour[r];
            colour[r] = tmp;
            c++;
            x = lfsr_next(x);
        end
        done_off = c;
        exp_deck = pack_deck(colour);
    endtask

    task automatic check_deck_shape(input string tag, input logic [127:0] d);
        int hist[8];
        int bad;
        int t;
        bad = 0;
        for (int c = 0; c < 8; c++) hist[c] = 0;
        for (int k = 0; k < NT; k++) begin
            t = tile_of(d, k);
            if (((t >> 1) & 63) < 8) hist[(t >> 1) & 63]++;
            if (((t >> 9) & 3) != k / 4 || ((t >> 7) & 3) != k % 4 || (t & 1) != 0) bad++;
        end
        for (int c = 1; c <= 5; c++) check_val($sformatf("%s_hist%0d", tag, c), hist[c], 2);
        check_val({tag, "_pos_fields"}, bad, 0);
    endtask

    task automatic do_shuffle(input int idle_n, input bit extra, input string tag);
        logic [15:0]  seed;
        logic [127:0] exp_deck, snap;
        int done_off, reduce_off, done_at;
        bit done_seen;
        repeat (idle_n) begin
            @(posedge CLOCK_50); #1;
        end
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        seed = m_lfsr;
        model_shuffle(seed, exp_deck, done_off, reduce_off);
        check_val({tag, "_busy_load"}, busy, 1'b1);
        check_val({tag, "_valid_load"}, deck_valid, 1'b0);
        done_seen = 1'b0;
        done_at = -1;
        for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
            start = (extra && cyc <= done_off) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge CLOCK_50); #1;
            if (done) begin
                done_seen = 1'b1;
                done_at = cyc;
            end
        end
        start = 1'b0;
        check_val({tag, "_done_cycle"}, done_at, done_off);
        check_val({tag, "_latency_le45"}, (done_at >= 0) && (done_at + 1 <= 45), 1'b1);
        check_val({tag, "_deck"}, deck, exp_deck);
        check_val({tag, "_valid_done"}, deck_valid, 1'b1);
        check_val({tag, "_busy_done"}, busy, 1'b0);
        check_deck_shape(tag, deck);
        snap = deck;
        @(posedge CLOCK_50); #1;
        check_val({tag, "_done_1cyc"}, done, 1'b0);
        repeat (4) begin
            @(posedge CLOCK_50); #1;
        end
        check_val({tag, "_idle_after"}, busy, 1'b0);
        check_val({tag, "_deck_hold"}, deck, snap);
        check_val({tag, "_valid_hold"}, deck_valid, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_deck;
        logic [15:0]  seed;
        int done_off, reduce_off, first_done, dones;
        bit busy_h[100];
        bit hit;

        // Reset
        userquit = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_valid", deck_valid, 1'b0);
        check_val("rst_tile0", tile_of(deck, 0), 11'h002);
        check_val("rst_tile9", tile_of(deck, 9), 11'h48A);
        check_val("rst_tile4", tile_of(deck, 4), 11'h206);
        check_val("rst_deck", deck, canon_deck());
        userquit = 1'b0;

        // Shuffles after various idle times, some with ignored extra starts
        do_shuffle(0, 1'b0, "n0");
        do_shuffle(7, 1'b0, "n7");
        do_shuffle(1000, 1'b0, "n1000");
        for (int t = 0; t < 3; t++) begin
            do_shuffle($urandom_range(1, 60), 1'b1, $sformatf("xtra%0d", t));
        end

        // start held high for 100 cycles
        start = 1'b1;
        first_done = -1;
        done_off = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge CLOCK_50); #1;
            if (cyc == 0) begin
                seed = m_lfsr;
                model_shuffle(seed, exp_deck, done_off, reduce_off);
            end
            busy_h[cyc] = busy;
            if (done && first_done < 0) first_done = cyc;
        end
        start = 1'b0;
        check_val("held_first_done", first_done, done_off);
        if (first_done >= 0 && first_done < 98) begin
            check_val("held_idle_gap", busy_h[first_done + 1], 1'b0);
            check_val("held_reload", busy_h[first_done + 2], 1'b1);
        end
        for (int n = 0; n < 60 && (busy || done); n++) begin
            @(posedge CLOCK_50); #1;
        end
        check_val("held_settled", busy | done, 1'b0);

        // userquit in the cycle after entering REDUCE
        hit = 1'b0;
        for (int t = 0; t < 8 && !hit; t++) begin
            repeat ($urandom_range(1, 30)) begin
                @(posedge CLOCK_50); #1;
            end
            start = 1'b1;
            @(posedge CLOCK_50); #1;
            start = 1'b0;
            seed = m_lfsr;
            model_shuffle(seed, exp_deck, done_off, reduce_off);
            if (reduce_off > 0) begin
                hit = 1'b1;
                repeat (reduce_off + 1) @(posedge CLOCK_50);
                #1;
                userquit = 1'b1;
                @(posedge CLOCK_50); #1;
                userquit = 1'b0;
                check_val("quit_busy", busy, 1'b0);
                check_val("quit_done", done, 1'b0);
                check_val("quit_valid", deck_valid, 1'b0);
                check_val("quit_deck", deck, canon_deck());
                dones = 0;
                for (int n = 0; n < 50; n++) begin
                    @(posedge CLOCK_50); #1;
                    if (done || busy) dones++;
                end
                check_val("quit_stays_idle", dones, 0);
            end else begin
                repeat (done_off + 2) @(posedge CLOCK_50);
                #1;
            end
        end
        check_val("quit_reduce_found", hit, 1'b1);

        // Shuffle once so deck_valid is set, then userquit with start together
        do_shuffle(3, 1'b0, "pre_sim");
        userquit = 1'b1;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        userquit = 1'b0;
        start = 1'b0;
        check_val("sim_busy0", busy, 1'b0);
        check_val("sim_valid", deck_valid, 1'b0);
        check_val("sim_deck", deck, canon_deck());
        @(posedge CLOCK_50); #1;
        check_val("sim_busy1", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
